// File: rtl/calc_port_initiator.sv
// Requester side of one calc2 port: tags host operations, drives the two-cycle command, buffers responses.
// Optional macro CALC_INIT_TIMEOUT_EN retires unanswered tags after TIMEOUT cycles with a resp=0 result.
module calc_port_initiator #(
   parameter int DATA_W  = 32,
   parameter int TAG_W   = 2,
   parameter int TIMEOUT = 64
) (
   input  logic              a_clk,
   input  logic              reset,
   input  logic              op_valid,
   output logic              op_ready,
   input  logic [3:0]        op_cmd,
   input  logic [DATA_W-1:0] op_a,
   input  logic [DATA_W-1:0] op_b,
   output logic [3:0]        cmd_out,
   output logic [DATA_W-1:0] data_out,
   output logic [TAG_W-1:0]  tag_out,
   input  logic [1:0]        resp_in,
   input  logic [DATA_W-1:0] data_in,
   input  logic [TAG_W-1:0]  tag_in,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [TAG_W-1:0]  res_tag,
   output logic [1:0]        res_resp,
   output logic [DATA_W-1:0] res_data,
   output logic [TAG_W:0]    outstanding,
   output logic              err_spurious
);

   localparam int NUM_TAGS = 2**TAG_W;

   typedef enum logic {IDLE, SEND_B} state_t;

   state_t              state_q, state_d;
   logic [NUM_TAGS-1:0] alloc_q, alloc_d;
   logic [NUM_TAGS-1:0] ans_q, ans_d;
   logic [3:0]          cmd_q, cmd_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [DATA_W-1:0]   opb_q, opb_d;
   logic [TAG_W-1:0]    tag_q, tag_d;
   logic [TAG_W:0]      outstanding_q, outstanding_d;
   logic                err_q, err_d;

   logic [TAG_W-1:0]    ftag_q  [NUM_TAGS];
   logic [TAG_W-1:0]    ftag_d  [NUM_TAGS];
   logic [1:0]          fresp_q [NUM_TAGS];
   logic [1:0]          fresp_d [NUM_TAGS];
   logic [DATA_W-1:0]   fdata_q [NUM_TAGS];
   logic [DATA_W-1:0]   fdata_d [NUM_TAGS];
   logic [TAG_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [TAG_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [TAG_W:0]      cnt_q, cnt_d;

   logic                free_found;
   logic [TAG_W-1:0]    free_tag;
   logic                accept, pop, push, resp_hit;
   logic                to_hit;
   logic [TAG_W-1:0]    to_tag;
   logic [TAG_W-1:0]    push_tag;
   logic [1:0]          push_resp;
   logic [DATA_W-1:0]   push_data;
   logic [TAG_W-1:0]    head_tag;

   always_comb begin
      free_found = 1'b0;
      free_tag   = '0;
      for (int i = NUM_TAGS-1; i >= 0; i--) begin
         if (!alloc_q[i]) begin
            free_found = 1'b1;
            free_tag   = TAG_W'(i);
         end
      end
   end

   assign op_ready  = (state_q == IDLE) && free_found;
   assign accept    = op_valid && op_ready;
   assign res_valid = (cnt_q != '0);
   assign pop       = res_valid && res_ready;
   assign head_tag  = ftag_q[rd_ptr_q];
   assign resp_hit  = (resp_in != 2'd0) && alloc_q[tag_in] && !ans_q[tag_in];

`ifdef CALC_INIT_TIMEOUT_EN
   localparam int TCW = $clog2(TIMEOUT+1);

   logic [TCW-1:0] tcnt_q [NUM_TAGS];
   logic [TCW-1:0] tcnt_d [NUM_TAGS];

   // Counters saturate at TIMEOUT so a timeout that loses the push slot retries next cycle.
   always_comb begin
      to_hit = 1'b0;
      to_tag = '0;
      for (int i = NUM_TAGS-1; i >= 0; i--) begin
         if (alloc_q[i] && !ans_q[i] && (tcnt_q[i] == TCW'(TIMEOUT)) &&
             !(resp_hit && (tag_in == TAG_W'(i)))) begin
            to_hit = 1'b1;
            to_tag = TAG_W'(i);
         end
      end
      for (int i = 0; i < NUM_TAGS; i++) begin
         tcnt_d[i] = tcnt_q[i];
         if (accept && (free_tag == TAG_W'(i))) begin
            tcnt_d[i] = '0;
         end else if (alloc_q[i] && !ans_q[i] && (tcnt_q[i] != TCW'(TIMEOUT))) begin
            tcnt_d[i] = tcnt_q[i] + TCW'(1);
         end
      end
   end

   always_ff @(posedge a_clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_TAGS; i++) tcnt_q[i] <= '0;
      end else begin
         tcnt_q <= tcnt_d;
      end
   end
`else
   assign to_hit = 1'b0;
   assign to_tag = '0;
`endif

   // A real response owns the single push slot; a pending timeout waits.
   always_comb begin
      push      = resp_hit || to_hit;
      push_tag  = resp_hit ? tag_in  : to_tag;
      push_resp = resp_hit ? resp_in : 2'd0;
      push_data = resp_hit ? data_in : '0;
   end

   always_comb begin
      alloc_d = alloc_q;
      ans_d   = ans_q;
      if (pop) begin
         alloc_d[head_tag] = 1'b0;
         ans_d[head_tag]   = 1'b0;
      end
      if (accept) begin
         alloc_d[free_tag] = 1'b1;
         ans_d[free_tag]   = 1'b0;
      end
      if (push) begin
         ans_d[push_tag] = 1'b1;
      end
      err_d = err_q || ((resp_in != 2'd0) && !resp_hit);

      outstanding_d = outstanding_q;
      case ({accept, pop})
         2'b10:   outstanding_d = outstanding_q + (TAG_W+1)'(1);
         2'b01:   outstanding_d = outstanding_q - (TAG_W+1)'(1);
         default: outstanding_d = outstanding_q;
      endcase
   end

   always_comb begin
      ftag_d   = ftag_q;
      fresp_d  = fresp_q;
      fdata_d  = fdata_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) begin
         ftag_d[wr_ptr_q]  = push_tag;
         fresp_d[wr_ptr_q] = push_resp;
         fdata_d[wr_ptr_q] = push_data;
         wr_ptr_d          = wr_ptr_q + TAG_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + TAG_W'(1);
      end
      cnt_d = cnt_q;
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + (TAG_W+1)'(1);
         2'b01:   cnt_d = cnt_q - (TAG_W+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cmd_d   = 4'd0;
      data_d  = '0;
      tag_d   = tag_q;
      opb_d   = opb_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               cmd_d   = op_cmd;
               data_d  = op_a;
               tag_d   = free_tag;
               opb_d   = op_b;
               state_d = SEND_B;
            end
         end
         SEND_B: begin
            data_d  = opb_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge a_clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         alloc_q       <= '0;
         ans_q         <= '0;
         cmd_q         <= 4'd0;
         data_q        <= '0;
         opb_q         <= '0;
         tag_q         <= '0;
         outstanding_q <= '0;
         err_q         <= 1'b0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         cnt_q         <= '0;
         for (int i = 0; i < NUM_TAGS; i++) begin
            ftag_q[i]  <= '0;
            fresp_q[i] <= 2'd0;
            fdata_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         alloc_q       <= alloc_d;
         ans_q         <= ans_d;
         cmd_q         <= cmd_d;
         data_q        <= data_d;
         opb_q         <= opb_d;
         tag_q         <= tag_d;
         outstanding_q <= outstanding_d;
         err_q         <= err_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         cnt_q         <= cnt_d;
         ftag_q        <= ftag_d;
         fresp_q       <= fresp_d;
         fdata_q       <= fdata_d;
      end
   end

   assign cmd_out      = cmd_q;
   assign data_out     = data_q;
   assign tag_out      = tag_q;
   assign res_tag      = head_tag;
   assign res_resp     = fresp_q[rd_ptr_q];
   assign res_data     = fdata_q[rd_ptr_q];
   assign outstanding  = outstanding_q;
   assign err_spurious = err_q;

endmodule

// File: tb/tb_calc_port_initiator.sv
// Directed bench for calc_port_initiator: stimulus pushes expected results, a monitor pops and compares.
module tb_calc_port_initiator;

   localparam int DATA_W  = 32;
   localparam int TAG_W   = 2;
   localparam int TIMEOUT = 64;

   typedef struct packed {
      logic [TAG_W-1:0]  tag;
      logic [1:0]        resp;
      logic [DATA_W-1:0] data;
   } res_t;

   logic              a_clk, reset;
   logic              op_valid, op_ready;
   logic [3:0]        op_cmd;
   logic [DATA_W-1:0] op_a, op_b;
   logic [3:0]        cmd_out;
   logic [DATA_W-1:0] data_out;
   logic [TAG_W-1:0]  tag_out;
   logic [1:0]        resp_in;
   logic [DATA_W-1:0] data_in;
   logic [TAG_W-1:0]  tag_in;
   logic              res_valid, res_ready;
   logic [TAG_W-1:0]  res_tag;
   logic [1:0]        res_resp;
   logic [DATA_W-1:0] res_data;
   logic [TAG_W:0]    outstanding;
   logic              err_spurious;

   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   res_t sb[$];

   calc_port_initiator #(.DATA_W(DATA_W), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
      .a_clk(a_clk), .reset(reset),
      .op_valid(op_valid), .op_ready(op_ready), .op_cmd(op_cmd), .op_a(op_a), .op_b(op_b),
      .cmd_out(cmd_out), .data_out(data_out), .tag_out(tag_out),
      .resp_in(resp_in), .data_in(data_in), .tag_in(tag_in),
      .res_valid(res_valid), .res_ready(res_ready), .res_tag(res_tag), .res_resp(res_resp),
      .res_data(res_data), .outstanding(outstanding), .err_spurious(err_spurious)
   );

   initial begin
      a_clk = 1'b0;
      forever #5 a_clk = ~a_clk;
   end

   initial begin
      forever begin
         @(posedge a_clk);
         cyc++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge a_clk);
      #1;
   endtask

   // Result monitor: compares the head entry whenever the host pops it.
   initial begin
      res_t e;
      forever begin
         @(negedge a_clk);
         if (!reset && res_valid && res_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_result: got tag %0d expected none", res_tag);
            end else begin
               e = sb.pop_front();
               chk("res_tag",  64'(res_tag),  64'(e.tag));
               chk("res_resp", 64'(res_resp), 64'(e.resp));
               chk("res_data", 64'(res_data), 64'(e.data));
            end
         end
      end
   end

   task automatic issue(input logic [3:0] cmd, input logic [DATA_W-1:0] a,
                        input logic [DATA_W-1:0] b, input logic [TAG_W-1:0] exp_tag);
      int n = 0;
      op_cmd = cmd; op_a = a; op_b = b; op_valid = 1'b1;
      while (!op_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("op_ready_wait", 64'(0), 64'(1));
      tick();
      chk("cmd_a",   64'(cmd_out),  64'(cmd));
      chk("data_a",  64'(data_out), 64'(a));
      chk("tag_a",   64'(tag_out),  64'(exp_tag));
      op_valid = 1'b0;
      tick();
      chk("cmd_b",   64'(cmd_out),  64'(0));
      chk("data_b",  64'(data_out), 64'(b));
      chk("tag_b",   64'(tag_out),  64'(exp_tag));
   endtask

   task automatic respond(input logic [TAG_W-1:0] t, input logic [1:0] r,
                          input logic [DATA_W-1:0] d, input bit exp_push);
      tag_in = t; resp_in = r; data_in = d;
      if (exp_push) sb.push_back('{tag: t, resp: r, data: d});
      tick();
      tag_in = '0; resp_in = 2'd0; data_in = '0;
   endtask

   task automatic pop_one();
      res_ready = 1'b1;
      tick();
      res_ready = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      res_ready = 1'b1;
      while (sb.size() != 0 && n < 50) begin
         tick();
         n++;
      end
      res_ready = 1'b0;
      if (n >= 50) chk("drain_wait", 64'(sb.size()), 64'(0));
   endtask

   initial begin
      int n;
      int c_issue;
      reset = 1'b1; op_valid = 1'b0; op_cmd = 4'd0; op_a = '0; op_b = '0;
      resp_in = 2'd0; data_in = '0; tag_in = '0; res_ready = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      chk("rst_op_ready",    64'(op_ready),     64'(1));
      chk("rst_outstanding", 64'(outstanding),  64'(0));
      chk("rst_res_valid",   64'(res_valid),    64'(0));
      chk("rst_cmd_out",     64'(cmd_out),      64'(0));
      chk("rst_err",         64'(err_spurious), 64'(0));

      // 5 + 3 on tag 0
      issue(4'd1, 32'd5, 32'd3, 2'd0);
      chk("out_after_issue", 64'(outstanding), 64'(1));
      respond(2'd0, 2'd1, 32'd8, 1'b1);
      chk("add_res_valid", 64'(res_valid), 64'(1));
      chk("add_res_tag",   64'(res_tag),   64'(0));
      chk("add_res_resp",  64'(res_resp),  64'(1));
      chk("add_res_data",  64'(res_data),  64'(8));
      pop_one();
      chk("add_out_zero",  64'(outstanding), 64'(0));
      chk("add_res_empty", 64'(res_valid),   64'(0));

      // Fill all four tags, answer out of order, nothing popped
      issue(4'd2, 32'h10, 32'h11, 2'd0);
      issue(4'd3, 32'h20, 32'h21, 2'd1);
      issue(4'd4, 32'h30, 32'h31, 2'd2);
      issue(4'd5, 32'h40, 32'h41, 2'd3);
      chk("full_outstanding", 64'(outstanding), 64'(4));
      tick();
      chk("full_op_ready", 64'(op_ready), 64'(0));
      respond(2'd1, 2'd2, 32'h111, 1'b1);
      respond(2'd3, 2'd1, 32'h333, 1'b1);
      respond(2'd0, 2'd3, 32'h100, 1'b1);
      respond(2'd2, 2'd1, 32'h222, 1'b1);
      chk("answered_op_ready", 64'(op_ready),    64'(0));
      chk("answered_out",      64'(outstanding), 64'(4));
      pop_one();
      chk("freed_op_ready", 64'(op_ready),    64'(1));
      chk("freed_out",      64'(outstanding), 64'(3));
      issue(4'd6, 32'h50, 32'h51, 2'd1);
      drain();
      respond(2'd1, 2'd2, 32'h555, 1'b1);
      drain();
      chk("p3_out_zero", 64'(outstanding), 64'(0));

      // Tags 0..2 in flight; answers for 2 then 0 pop in arrival order
      issue(4'd7, 32'h1, 32'h2, 2'd0);
      issue(4'd7, 32'h3, 32'h4, 2'd1);
      issue(4'd7, 32'h5, 32'h6, 2'd2);
      respond(2'd2, 2'd1, 32'hA2, 1'b1);
      respond(2'd0, 2'd2, 32'hA0, 1'b1);
      pop_one();
      pop_one();
      chk("p4_out", 64'(outstanding), 64'(1));
      issue(4'd8, 32'h7, 32'h8, 2'd0);
      respond(2'd0, 2'd1, 32'hB0, 1'b1);
      // accept and pop in the same cycle
      op_cmd = 4'd9; op_a = 32'hC1; op_b = 32'hC2; op_valid = 1'b1; res_ready = 1'b1;
      chk("p4_sim_ready", 64'(op_ready), 64'(1));
      tick();
      op_valid = 1'b0; res_ready = 1'b0;
      chk("p4_sim_out", 64'(outstanding), 64'(2));
      chk("p4_sim_tag", 64'(tag_out),     64'(2));
      chk("p4_sim_cmd", 64'(cmd_out),     64'(9));
      tick();
      respond(2'd1, 2'd3, 32'hD1, 1'b1);
      respond(2'd2, 2'd1, 32'hD2, 1'b1);
      drain();
      chk("p4_out_zero", 64'(outstanding), 64'(0));

      // Response for a free tag is dropped and flagged
      respond(2'd3, 2'd1, 32'hDEAD, 1'b0);
      chk("spur_err",   64'(err_spurious), 64'(1));
      chk("spur_valid", 64'(res_valid),    64'(0));
      repeat (3) tick();
      chk("spur_held",  64'(err_spurious), 64'(1));

      // Reset in the middle of SEND_B with a buffered result
      issue(4'd1, 32'h9, 32'hA, 2'd0);
      respond(2'd0, 2'd1, 32'h13, 1'b0);
      chk("pre_rst_valid", 64'(res_valid), 64'(1));
      op_cmd = 4'd2; op_a = 32'hAA; op_b = 32'hBB; op_valid = 1'b1;
      tick();
      op_valid = 1'b0;
      tick();
      chk("pre_rst_data", 64'(data_out), 64'(32'hBB));
      #2 reset = 1'b1;
      #1;
      chk("rst_mid_cmd",   64'(cmd_out),      64'(0));
      chk("rst_mid_data",  64'(data_out),     64'(0));
      chk("rst_mid_tag",   64'(tag_out),      64'(0));
      chk("rst_mid_valid", 64'(res_valid),    64'(0));
      chk("rst_mid_out",   64'(outstanding),  64'(0));
      chk("rst_mid_err",   64'(err_spurious), 64'(0));
      tick();
      reset = 1'b0;
      chk("post_rst_ready", 64'(op_ready), 64'(1));

`ifdef CALC_INIT_TIMEOUT_EN
      // Unanswered tag 0 retires TIMEOUT cycles after its command is driven
      issue(4'd1, 32'h1, 32'h2, 2'd0);
      c_issue = cyc - 1;
      n = 0;
      while (!res_valid && n < 200) begin
         tick();
         n++;
      end
      chk("to_valid", 64'(res_valid), 64'(1));
      chk("to_cycle", 64'(cyc), 64'(c_issue + TIMEOUT + 1));
      sb.push_back('{tag: 2'd0, resp: 2'd0, data: 32'd0});
      respond(2'd0, 2'd1, 32'h77, 1'b0);
      chk("to_late_err", 64'(err_spurious), 64'(1));
      drain();
      chk("to_out_zero", 64'(outstanding), 64'(0));
`else
      n = 0;
      c_issue = 0;
`endif

      repeat (2) tick();
      chk("sb_empty", 64'(sb.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
